// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults for the multi-ported register file.
//   XLEN_DEF  - default data width in bits
//   NREGS_DEF - default register count (power of two, >= 2)
//   NRD_DEF   - default number of combinational read ports
//   NWR_DEF   - default number of write ports
//   addr_w()  - index width derived from a register count
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int NWR_DEF   = 2;

  function automatic int addr_w(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/rf_write_merge.sv
// rf_write_merge: write selection for one target index.
// Scans every write port and reports whether any enabled port targets tgt,
// together with the data of the winning port (highest port number wins).
// Used once per stored register (storage update) and once per read port
// (same-cycle bypass), so both paths agree on the winner by construction.
//   tgt      in  AW        index being examined
//   wr_en    in  NWR       per-port write enable
//   wr_idx   in  NWR*AW    packed write indices
//   wr_data  in  NWR*XLEN  packed write data
//   hit      out 1         some enabled port targets tgt
//   win_data out XLEN      data of the winning port (don't care when !hit)
module rf_write_merge #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NWR  = 2
) (
  input  logic [AW-1:0]       tgt,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_idx,
  input  logic [NWR*XLEN-1:0] wr_data,
  output logic                hit,
  output logic [XLEN-1:0]     win_data
);

  localparam int PW = (NWR > 1) ? $clog2(NWR) : 1;

  logic [PW-1:0] win_port;

  // Ascending scan: a later (higher-numbered) match overwrites an earlier one.
  always_comb begin
    hit      = 1'b0;
    win_port = '0;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && (wr_idx[p*AW +: AW] == tgt)) begin
        hit      = 1'b1;
        win_port = PW'(p);
      end
    end
  end

  assign win_data = wr_data[win_port*XLEN +: XLEN];

endmodule

// File: rtl/mp_regfile.sv
// mp_regfile: multi-ported register file with a busy scoreboard.
// Register 0 is hardwired to zero and can never be busy. Reads are
// combinational; with BYPASS=1 a same-cycle write is forwarded to readers.
//   clk       in  1         rising-edge clock
//   rst_n     in  1         asynchronous active-low reset
//   rd_idx    in  NRD*AW    packed read indices, port p at [p*AW +: AW]
//   rd_data   out NRD*XLEN  packed read data
//   rd_busy   out NRD       per read port: register has a pending write
//   wr_en     in  NWR       per write port enable
//   wr_idx    in  NWR*AW    packed write indices
//   wr_data   in  NWR*XLEN  packed write data
//   claim_en  in  1         mark claim_idx busy
//   claim_idx in  AW        register to mark busy
//   flush     in  1         clear every busy bit
//   busy_vec  out NREGS     registered scoreboard
module mp_regfile
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int NWR    = NWR_DEF,
  parameter int BYPASS = 1,
  localparam int AW    = addr_w(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_idx,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_idx,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_idx,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  regs      [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [NREGS-1:1] reg_hit;
  logic [XLEN-1:0]  reg_wdata [1:NREGS-1];

  // Per-register write selection; register 0 has no merge and is never written.
  for (genvar r = 1; r < NREGS; r++) begin : g_reg_merge
    rf_write_merge #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_merge (
      .tgt      (AW'(r)),
      .wr_en    (wr_en),
      .wr_idx   (wr_idx),
      .wr_data  (wr_data),
      .hit      (reg_hit[r]),
      .win_data (reg_wdata[r])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (reg_hit[i]) regs[i] <= reg_wdata[i];
      end
    end
  end

  // Scoreboard priority: flush > claim > write-clear. Bit 0 is never set.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (claim_en && (claim_idx == AW'(i))) busy_nxt[i] = 1'b1;
        else if (reg_hit[i])                   busy_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign busy_vec = busy;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   ridx;
    logic [XLEN-1:0] stored;

    assign ridx   = rd_idx[p*AW +: AW];
    assign stored = (ridx == '0) ? '0 : regs[ridx];

    if (BYPASS != 0) begin : g_byp
      logic            byp_hit;
      logic [XLEN-1:0] byp_data;
      logic            byp_live;
      logic            claimed;

      rf_write_merge #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_merge (
        .tgt      (ridx),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .hit      (byp_hit),
        .win_data (byp_data)
      );

      // A write landing this edge resolves the hazard unless a claim
      // re-arms the same register in the same cycle.
      assign byp_live = byp_hit && (ridx != '0);
      assign claimed  = claim_en && (claim_idx == ridx);
      assign rd_data[p*XLEN +: XLEN] = byp_live ? byp_data : stored;
      assign rd_busy[p] = (byp_live && !claimed) ? 1'b0 : busy[ridx];
    end else begin : g_nobyp
      assign rd_data[p*XLEN +: XLEN] = stored;
      assign rd_busy[p] = busy[ridx];
    end
  end

endmodule
